// File: rtl/seqdet_scan_ctrl.sv
//==============================================================================
// Module      : seqdet_scan_ctrl
// Description : Frame controller that serializes words MSB-first into a 4-bit
//               programmable pattern matcher and counts matches per frame.
//               Optional abort input enabled by macro SEQDET_ABORT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seqdet_scan_ctrl #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_pattern,
    input  logic              cfg_overlap,
    input  logic              start,
    input  logic [7:0]        frame_len,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
`ifdef SEQDET_ABORT_EN
    input  logic              abort,
`endif
    output logic              in_ready,
    output logic              busy,
    output logic              hit,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              done
);

    localparam int c_IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_n;

    logic [3:0]           r_pattern;
    logic                 r_overlap;
    logic [3:0]           r_hist;
    logic [2:0]           r_fill;
    logic [7:0]           r_words_left;
    logic [WORD_W-1:0]    r_shreg;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic                 r_hit;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_start;
    logic                 w_accept;
    logic                 w_shift;
    logic [3:0]           w_hist_n;
    logic [2:0]           w_fill_inc;
    logic [2:0]           w_fill_n;
    logic                 w_match;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_start   = 1'b0;
        w_accept  = 1'b0;
        w_shift   = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_start   = 1'b1;
                    w_state_n = (frame_len == 8'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept  = 1'b1;
                    w_state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_bit_idx == '0) begin
                    w_state_n = (r_words_left == 8'd1) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
`ifdef SEQDET_ABORT_EN
        // Abort wins over any same-cycle handshake or shift
        if (abort && (r_state != S_IDLE)) begin
            w_state_n = S_IDLE;
            w_accept  = 1'b0;
            w_shift   = 1'b0;
        end
`endif
    end

    assign w_hist_n   = {r_hist[2:0], r_shreg[WORD_W-1]};
    assign w_fill_inc = (r_fill == 3'd4) ? 3'd4 : (r_fill + 3'd1);
    assign w_match    = (w_hist_n == r_pattern) && (w_fill_inc == 3'd4);
    // Non-overlapping mode restarts the fill so the next match needs 4 new bits
    assign w_fill_n   = (w_match && !r_overlap) ? 3'd0 : w_fill_inc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pattern    <= 4'b1001;
            r_overlap    <= 1'b1;
            r_hist       <= 4'd0;
            r_fill       <= 3'd0;
            r_words_left <= 8'd0;
            r_shreg      <= '0;
            r_bit_idx    <= '0;
            r_hit        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_hit <= 1'b0;
            if ((r_state == S_IDLE) && cfg_we) begin
                r_pattern <= cfg_pattern;
                r_overlap <= cfg_overlap;
            end
            if (w_start) begin
                r_words_left <= frame_len;
                r_cnt        <= '0;
                r_hist       <= 4'd0;
                r_fill       <= 3'd0;
            end
            if (w_accept) begin
                r_shreg   <= in_data;
                r_bit_idx <= c_IDX_W'(WORD_W - 1);
            end
            if (w_shift) begin
                r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
                r_bit_idx <= r_bit_idx - 1'b1;
                r_hist    <= w_hist_n;
                r_fill    <= w_fill_n;
                r_hit     <= w_match;
                if (w_match && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if ((r_bit_idx == '0) && (r_words_left != 8'd1)) begin
                    r_words_left <= r_words_left - 8'd1;
                end
            end
        end
    end

    assign hit       = r_hit;
    assign match_cnt = r_cnt;

endmodule

`default_nettype wire
